// File: rtl/instamp_cal_ctrl.sv
// ---------------------------------------------------------------------------
// instamp_cal_ctrl
//   Offset-trim calibration controller for an instrumentation amplifier.
//   A calibration request latches the gain code, shorts the amplifier inputs
//   (auto-zero), then runs a successive-approximation search on the trim code
//   using an offset comparator. After the last bit it releases the inputs
//   and runs the chopper.
//
// Parameters
//   TRIM_W     width of the offset-trim code
//   AZ_CYCLES  auto-zero phase length in clk cycles (>= 1)
//
// Ports
//   clk         clock, all state on rising edge
//   rst         synchronous active-high reset
//   ena         block enable; low forces idle
//   cal_start   single-cycle calibration request
//   gain_sel    requested gain code
//   cmp_in      asynchronous comparator (1 = trim too high)
//   settle_cfg  SAR settle length N = 4*(settle_cfg+1) cycles
//   chop_div    chopper half-period = chop_div+1 cycles
//   gain_out    latched gain code
//   trim_out    offset-trim code
//   az_sw       auto-zero switch (1 = inputs shorted)
//   chop        chopper phase
//   busy        calibration in progress
//   cal_done    trim_out holds a valid result
// ---------------------------------------------------------------------------
module instamp_cal_ctrl #(
  parameter int TRIM_W    = 6,
  parameter int AZ_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              cal_start,
  input  logic [2:0]        gain_sel,
  input  logic              cmp_in,
  input  logic [3:0]        settle_cfg,
  input  logic [3:0]        chop_div,
  output logic [2:0]        gain_out,
  output logic [TRIM_W-1:0] trim_out,
  output logic              az_sw,
  output logic              chop,
  output logic              busy,
  output logic              cal_done
);

  typedef enum logic [2:0] {
    IDLE,
    AUTOZERO,
    SETTLE,
    SAMPLE,
    RUN
  } state_t;

  localparam int AZ_W = (AZ_CYCLES > 1) ? $clog2(AZ_CYCLES) : 1;
  // counter is shared by auto-zero, settle (max 63) and chopper phases
  localparam int CW   = (AZ_W > 6) ? AZ_W : 6;
  localparam int IW   = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;

  localparam logic [TRIM_W-1:0] MID      = TRIM_W'(1) << (TRIM_W - 1);
  localparam logic [IW-1:0]     IDX_MSB  = IW'(TRIM_W - 1);
  localparam logic [CW-1:0]     AZ_LOAD  = CW'(AZ_CYCLES - 1);

  state_t              state_q, state_n;
  logic [CW-1:0]       cnt_q, cnt_n;
  logic [IW-1:0]       idx_q, idx_n;
  logic [TRIM_W-1:0]   trim_n;
  logic [2:0]          gain_n;
  logic                az_n, chop_n, busy_n, done_n;
  logic [1:0]          cmp_sync_q;
  logic                cmp_s;
  logic                accept;
  logic [CW-1:0]       settle_load;

  // two-flop synchronizer for the asynchronous comparator
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_sync_q <= '0;
    end else begin
      cmp_sync_q <= {cmp_sync_q[0], cmp_in};
    end
  end

  assign cmp_s = cmp_sync_q[1];

  // N-1 = 4*(settle_cfg+1)-1 = {settle_cfg, 2'b11}
  assign settle_load = CW'({settle_cfg, 2'b11});

  assign accept = cal_start && ((state_q == IDLE) || (state_q == RUN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      trim_out <= MID;
      gain_out <= '0;
      az_sw    <= 1'b0;
      chop     <= 1'b0;
      busy     <= 1'b0;
      cal_done <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      idx_q    <= idx_n;
      trim_out <= trim_n;
      gain_out <= gain_n;
      az_sw    <= az_n;
      chop     <= chop_n;
      busy     <= busy_n;
      cal_done <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    trim_n  = trim_out;
    gain_n  = gain_out;
    az_n    = az_sw;
    chop_n  = chop;
    busy_n  = busy;
    done_n  = cal_done;

    if (!ena) begin
      state_n = IDLE;
      az_n    = 1'b0;
      chop_n  = 1'b0;
      busy_n  = 1'b0;
      // an interrupted search leaves no valid result; a finished one stays valid
      if ((state_q == AUTOZERO) || (state_q == SETTLE) || (state_q == SAMPLE)) begin
        done_n = 1'b0;
      end
    end else if (accept) begin
      state_n = AUTOZERO;
      gain_n  = gain_sel;
      trim_n  = MID;
      idx_n   = IDX_MSB;
      cnt_n   = AZ_LOAD;
      az_n    = 1'b1;
      busy_n  = 1'b1;
      done_n  = 1'b0;
      chop_n  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_n = IDLE;
        end
        AUTOZERO: begin
          if (cnt_q == '0) begin
            state_n = SETTLE;
            cnt_n   = settle_load;
          end else begin
            cnt_n = cnt_q - CW'(1);
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_n = SAMPLE;
          end else begin
            cnt_n = cnt_q - CW'(1);
          end
        end
        SAMPLE: begin
          if (cmp_s) begin
            trim_n[idx_q] = 1'b0;
          end
          if (idx_q != '0) begin
            trim_n[idx_q - IW'(1)] = 1'b1;
            idx_n   = idx_q - IW'(1);
            cnt_n   = settle_load;
            state_n = SETTLE;
          end else begin
            state_n = RUN;
            az_n    = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            chop_n  = 1'b0;
            cnt_n   = CW'(chop_div);
          end
        end
        RUN: begin
          // reload from the live chop_div at each toggle
          if (cnt_q == '0) begin
            chop_n = ~chop;
            cnt_n  = CW'(chop_div);
          end else begin
            cnt_n = cnt_q - CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          az_n    = 1'b0;
          chop_n  = 1'b0;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instamp_cal_ctrl.sv
// ---------------------------------------------------------------------------
// tb_instamp_cal_ctrl
//   Self-checking bench for instamp_cal_ctrl (TRIM_W=6, AZ_CYCLES=32).
//   The amplifier/comparator is modelled as a function of trim_out; expected
//   trim codes come from a binary-search model, expected timing from the
//   documented cycle formula.
// ---------------------------------------------------------------------------
module tb_instamp_cal_ctrl;

  logic       clk = 1'b0;
  logic       rst, ena, cal_start, cmp_in;
  logic [2:0] gain_sel, gain_out;
  logic [3:0] settle_cfg, chop_div;
  logic [5:0] trim_out;
  logic       az_sw, chop, busy, cal_done;

  int mode;   // 0: comparator low, 1: comparator high, 2: high when trim > thr
  int thr;
  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  always_comb begin
    if (mode == 0)      cmp_in = 1'b0;
    else if (mode == 1) cmp_in = 1'b1;
    else                cmp_in = (int'(trim_out) > thr);
  end

  instamp_cal_ctrl #(
    .TRIM_W   (6),
    .AZ_CYCLES(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .cal_start (cal_start),
    .gain_sel  (gain_sel),
    .cmp_in    (cmp_in),
    .settle_cfg(settle_cfg),
    .chop_div  (chop_div),
    .gain_out  (gain_out),
    .trim_out  (trim_out),
    .az_sw     (az_sw),
    .chop      (chop),
    .busy      (busy),
    .cal_done  (cal_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Binary search: keep each trial bit unless the comparator says "too high".
  function automatic int sar_model(input int m, input int t);
    int r = 0;
    for (int b = 5; b >= 0; b--) begin
      int trial = r | (1 << b);
      bit hi = (m == 0) ? 1'b0 : (m == 1) ? 1'b1 : (trial > t);
      if (!hi) r = trial;
    end
    return r;
  endfunction

  // Full calibration from acceptance to RUN entry, with exact-latency checks.
  task automatic run_cal(input logic [2:0] g, input logic [3:0] s, input int m,
                         input int t, input int pulse_at, input string tag);
    int n        = 4 * (int'(s) + 1);
    int lat      = 32 + 6 * (n + 1);
    int exp_trim = sar_model(m, t);
    mode = m; thr = t; gain_sel = g; settle_cfg = s; cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || az_sw !== 1'b1 || cal_done !== 1'b0 || chop !== 1'b0)
      $display("FAIL %s_start: busy/az/done/chop=%b%b%b%b expected 1100", tag, busy, az_sw, cal_done, chop);
    else pass_cnt++;
    total_cnt++;
    if (gain_out !== g || trim_out !== 6'h20)
      $display("FAIL %s_load: gain=%0d trim=%0h expected gain=%0d trim=20", tag, gain_out, trim_out, g);
    else pass_cnt++;
    for (int j = 1; j < lat; j++) begin
      if (j == pulse_at) begin
        cal_start = 1'b1;
        gain_sel  = ~g;
      end
      tick();
      cal_start = 1'b0;
      gain_sel  = g;
    end
    total_cnt++;
    if (busy !== 1'b1 || cal_done !== 1'b0 || az_sw !== 1'b1)
      $display("FAIL %s_prerun: busy/done/az=%b%b%b expected 101", tag, busy, cal_done, az_sw);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || cal_done !== 1'b1 || az_sw !== 1'b0)
      $display("FAIL %s_run: busy/done/az=%b%b%b expected 010", tag, busy, cal_done, az_sw);
    else pass_cnt++;
    total_cnt++;
    if (trim_out !== 6'(exp_trim) || gain_out !== g)
      $display("FAIL %s_result: trim=%0h gain=%0d expected trim=%0h gain=%0d", tag, trim_out, gain_out, exp_trim, g);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; cal_start = 1'b1; gain_sel = 3'd7;
    tick();
    tick();
    rst = 1'b0; cal_start = 1'b0;
    total_cnt++;
    if (gain_out !== 3'd0 || trim_out !== 6'h20 || az_sw !== 1'b0 || chop !== 1'b0 ||
        busy !== 1'b0 || cal_done !== 1'b0)
      $display("FAIL reset: gain=%0d trim=%0h az=%b chop=%b busy=%b done=%b expected 0 20 0 0 0 0",
               gain_out, trim_out, az_sw, chop, busy, cal_done);
    else pass_cnt++;
  endtask

  task automatic test_cmp_low();
    run_cal(3'd5, 4'd0, 0, 0, -1, "cmp_low");
  endtask

  task automatic test_cmp_high();
    run_cal(3'd2, 4'd0, 1, 0, -1, "cmp_high");
  endtask

  task automatic test_threshold();
    run_cal(3'd3, 4'd1, 2, 42, -1, "thr42");
  endtask

  task automatic test_chop();
    chop_div = 4'd2;
    // a request during auto-zero must not disturb gain or timing
    run_cal(3'd6, 4'd0, 0, 0, 10, "busy_ignore");
    for (int j = 0; j <= 10; j++) begin
      total_cnt++;
      if (chop !== 1'((j / 3) % 2) || az_sw !== 1'b0)
        $display("FAIL chop_j%0d: chop=%b az=%b expected chop=%0d az=0", j, chop, az_sw, (j / 3) % 2);
      else pass_cnt++;
      if (j < 10) tick();
    end
    // chop is high here; restart from RUN must force it low
    run_cal(3'd1, 4'd0, 2, 17, -1, "restart");
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      logic [2:0] g  = 3'($urandom_range(0, 7));
      logic [3:0] s  = 4'($urandom_range(0, 3));
      int         t  = int'($urandom_range(0, 63));
      int         cd = int'($urandom_range(0, 5));
      chop_div = 4'(cd);
      run_cal(g, s, 2, t, -1, $sformatf("rand%0d", it));
      for (int j = 0; j < 2 * (cd + 1) + 2; j++) begin
        total_cnt++;
        if (chop !== 1'((j / (cd + 1)) % 2))
          $display("FAIL rand%0d_chop_j%0d: chop=%b expected %0d", it, j, chop, (j / (cd + 1)) % 2);
        else pass_cnt++;
        tick();
      end
    end
  endtask

  task automatic test_ena_abort();
    mode = 0; settle_cfg = 4'd0; gain_sel = 3'd4; cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    // bit 3 settles during edges k+42..k+45
    for (int j = 1; j <= 43; j++) tick();
    ena = 1'b0; cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    total_cnt++;
    if (busy !== 1'b0 || cal_done !== 1'b0 || az_sw !== 1'b0 || chop !== 1'b0)
      $display("FAIL abort_settle: busy/done/az/chop=%b%b%b%b expected 0000", busy, cal_done, az_sw, chop);
    else pass_cnt++;
    total_cnt++;
    if (trim_out !== 6'h38 || gain_out !== 3'd4)
      $display("FAIL abort_hold: trim=%0h gain=%0d expected trim=38 gain=4", trim_out, gain_out);
    else pass_cnt++;
    tick();
    ena = 1'b1;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || az_sw !== 1'b0 || trim_out !== 6'h38)
      $display("FAIL abort_idle: busy=%b az=%b trim=%0h expected 0 0 38", busy, az_sw, trim_out);
    else pass_cnt++;
    // from IDLE, complete a calibration, then disable during RUN
    chop_div = 4'd0;
    run_cal(3'd2, 4'd0, 2, 9, -1, "from_idle");
    tick();
    ena = 1'b0;
    tick();
    total_cnt++;
    if (cal_done !== 1'b1 || chop !== 1'b0 || busy !== 1'b0 || trim_out !== 6'd9)
      $display("FAIL abort_run: done=%b chop=%b busy=%b trim=%0h expected 1 0 0 9", cal_done, chop, busy, trim_out);
    else pass_cnt++;
    ena = 1'b1;
    tick();
  endtask

  task automatic test_rst_mid_az();
    gain_sel = 3'd5; cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    for (int j = 0; j < 10; j++) tick();
    total_cnt++;
    if (busy !== 1'b1 || az_sw !== 1'b1)
      $display("FAIL az_mid: busy=%b az=%b expected 1 1", busy, az_sw);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++;
    if (gain_out !== 3'd0 || trim_out !== 6'h20 || az_sw !== 1'b0 || chop !== 1'b0 ||
        busy !== 1'b0 || cal_done !== 1'b0)
      $display("FAIL rst_mid_az: gain=%0d trim=%0h az=%b chop=%b busy=%b done=%b expected 0 20 0 0 0 0",
               gain_out, trim_out, az_sw, chop, busy, cal_done);
    else pass_cnt++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ena = 1'b1; cal_start = 1'b0; gain_sel = '0;
    settle_cfg = '0; chop_div = 4'd2; mode = 0; thr = 0;
    test_reset();
    test_cmp_low();
    test_cmp_high();
    test_threshold();
    test_chop();
    test_random();
    test_ena_abort();
    test_rst_mid_az();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instamp_cal_ctrl.md
INSTAMP_CAL_CTRL -- requirements
Module: instamp_cal_ctrl

Interface
REQ-001 Parameter TRIM_W, default 6, width of the offset-trim code.
REQ-002 Parameter AZ_CYCLES, default 32, auto-zero phase length in clk cycles (≥1).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 ena  input  1  block enable; low forces the idle/safe state.
REQ-006 cal_start  input  1  single-cycle calibration request.
REQ-007 gain_sel  input  3  requested amplifier gain code.
REQ-008 cmp_in  input  1  asynchronous offset-comparator output; 1 = amp output above midscale, meaning trim is too high.
REQ-009 settle_cfg  input  4  SAR settle length N = 4*(settle_cfg+1) cycles.
REQ-010 chop_div  input  4  chopper half-period = chop_div+1 cycles.
REQ-011 gain_out  output  3  gain code driven to the amplifier.
REQ-012 trim_out  output  TRIM_W  offset-trim code driven to the amplifier.
REQ-013 az_sw  output  1  auto-zero switch; 1 = amplifier inputs shorted.
REQ-014 chop  output  1  chopper phase.
REQ-015 busy  output  1  calibration in progress.
REQ-016 cal_done  output  1  trim_out holds a valid calibration result.

Function
REQ-017 cmp_in SHALL pass through a 2-flop synchronizer; every SAR decision SHALL use the synchronized value.
REQ-018 FSM states SHALL be IDLE, AUTOZERO, SETTLE, SAMPLE, RUN.
REQ-019 A cal_start sampled high with ena=1 in IDLE or RUN SHALL be accepted; it is ignored in AUTOZERO, SETTLE and SAMPLE.
REQ-020 On acceptance the next state SHALL be AUTOZERO, with the following loaded at the same edge:
- gain_out = gain_sel, latched; held until the next accepted cal_start.
- trim_out = midscale (MSB=1, rest 0); bit index = MSB.
- az_sw=1, busy=1, cal_done=0, chop=0.
REQ-021 AUTOZERO SHALL last exactly AZ_CYCLES cycles, then enter SETTLE.
REQ-022 SETTLE SHALL last exactly N cycles, then enter SAMPLE; settle_cfg SHALL be sampled when SETTLE is entered.
REQ-023 SAMPLE SHALL last one cycle and act as follows:
- Synchronized cmp_in=1: clear the current trial bit.
- Not at the LSB: set the next lower bit to 1, decrement the index, enter SETTLE.
- At the LSB: enter RUN.
REQ-024 az_sw SHALL stay 1 through AUTOZERO, SETTLE and SAMPLE.
REQ-025 Accepted cal_start to RUN entry SHALL take exactly AZ_CYCLES + TRIM_W*(N+1) cycles.
REQ-026 On entering RUN, az_sw=0, busy=0 and cal_done=1.
REQ-027 In RUN, chop SHALL toggle every chop_div+1 cycles, with the first toggle chop_div+1 cycles after RUN entry.
REQ-028 chop SHALL be 0 in every state other than RUN.
REQ-029 A chop_div change in RUN SHALL take effect at the next toggle.
REQ-030 ena=0 in any state SHALL force IDLE at the next edge, with:
- az_sw=0, chop=0, busy=0.
- trim_out and gain_out retained.
- cal_done cleared if the abort occurred in AUTOZERO, SETTLE or SAMPLE; retained if it occurred in RUN.
REQ-031 ena=0 SHALL take priority over a simultaneous cal_start.
REQ-032 An accepted cal_start in RUN SHALL restart calibration per REQ-020.
REQ-033 In IDLE, az_sw=0, chop=0 and busy=0.

Reset
REQ-034 rst=1 at an edge SHALL, from any state including mid-calibration, set:
- State IDLE.
- gain_out=0, trim_out=midscale (0x20 for TRIM_W=6).
- az_sw=0, chop=0, busy=0, cal_done=0.
- Synchronizer flops and all counters cleared.
REQ-035 rst SHALL take priority over ena and cal_start.

Verification
REQ-036 The bench SHALL cover the following directed scenarios (TRIM_W=6, AZ_CYCLES=32 unless noted):
- Reset: rst high for 2 cycles -> gain_out=0, trim_out=0x20, az_sw=0, chop=0, busy=0, cal_done=0.
- cmp_in tied 0, settle_cfg=0, gain_sel=5, cal_start at edge k -> busy=1 and az_sw=1 after edge k; gain_out=5; trim_out=0x3F; busy=0, cal_done=1, az_sw=0 after edge k+62.
- cmp_in tied 1, settle_cfg=0 -> trim_out=0x00 after edge k+62, cal_done=1.
- Comparator model cmp_in=(trim_out>42), settle_cfg=1 (N=8) -> final trim_out=42 (0x2A) after edge k+32+54=k+86.
- RUN with chop_div=2 -> chop toggles every 3 cycles; az_sw=0; a cal_start during busy is ignored; a cal_start in RUN restarts calibration with chop=0.
- ena dropped during SETTLE of bit 3 -> next edge IDLE, busy=0, cal_done=0, az_sw=0, trim_out held; rst asserted mid-AUTOZERO -> full reset values.
